npu_circ_buf_param: RTL and testbench
=====================================

Name: npu_circ_buf_param

Overview:
Parametrised successor to the NPU circular buffer. It is a single-clock ring buffer with configurable data width and depth. It adds full/empty/occupancy status, a selectable overflow policy (drop newest or overwrite oldest), sticky error flags and a synchronous flush. It sits between NPU producer stages (e.g. the sample generator) and consumer stages, and replaces the fixed 16-bit buffer.

Parameters:
DATA_W, 16, width of each stored word
DEPTH, 64, number of entries; any integer >= 2 (not restricted to powers of two)
OVERWRITE, 0, 0 = write while full is dropped; 1 = write while full overwrites oldest entry
CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
CLK  in  1  system clock, rising edge
npu_rst_n  in  1  asynchronous active-low reset
npu_circ_buf_flush  in  1  synchronous clear of contents and flags
npu_circ_buf_write_en  in  1  write request
npu_circ_buf_data_input  in  DATA_W  write data
npu_circ_buf_read_en  in  1  read request
npu_circ_buf_data_output  out  DATA_W  registered read data
npu_circ_buf_rd_valid  out  1  data_output updated this cycle (1-cycle pulse)
npu_circ_buf_full  out  1  count == DEPTH
npu_circ_buf_empty  out  1  count == 0
npu_circ_buf_count  out  CNT_W  current occupancy
npu_circ_buf_overflow  out  1  sticky: a write hit a full buffer
npu_circ_buf_underflow  out  1  sticky: a read hit an empty buffer

Behaviour:
- Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, data_output=0, rd_valid=0, empty=1, full=0, overflow=0, underflow=0. Storage contents are not reset.
- Pointers wrap from DEPTH-1 to 0 (explicit compare, no power-of-two masking).
- full and empty are driven combinationally from registered count, so they are glitch-free and reflect the state after the previous edge.
- Read:
  - Accepted if read_en && !empty.
  - data_output <= mem[rd_ptr]; rd_valid=1 next cycle; rd_ptr advances.
  - Latency is 1 cycle. data_output holds its value when no read is accepted.
  - read_en while empty: no pointer change, rd_valid=0, underflow set.
- Write when not full: mem[wr_ptr] <= data_input; wr_ptr advances.
- Write when full, OVERWRITE=0:
  - With no accepted read: write dropped, overflow set, no state change.
  - With an accepted read: both proceed, count stays DEPTH, overflow not set.
- Write when full, OVERWRITE=1:
  - With no read: write stored, wr_ptr and rd_ptr both advance (oldest discarded), count stays DEPTH, overflow set.
  - With a read: normal simultaneous read and write, overflow not set.
- Simultaneous read+write when empty: write accepted, read rejected (no fall-through bypass), underflow set, count becomes 1.
- Simultaneous read+write otherwise: both accepted, count unchanged. The read returns the old entry; the same address is never read and written in one cycle except in the full case, where the read takes pre-write data.
- count update: +1 on write-only, -1 on read-only, unchanged on both or neither. Never exceeds DEPTH and never wraps below 0.
- Flush:
  - Same effect as reset, except data_output is held.
  - Flush has priority over read/write in the same cycle; those requests are ignored.
  - Clears overflow and underflow.
- Sticky flags clear only on reset or flush.
- No combinational path from inputs to any output.

Decomposition:
- Shared package npu_buf_pkg:
  - OVF_DROP=0 and OVF_OVERWRITE=1 constants.
  - clog2 helper function.
  - Default DATA_W/DEPTH constants shared with other NPU buffers.
- One sub-module, npu_circ_ptr: a modulo-DEPTH pointer register.
  - Ports: CLK, npu_rst_n, clr, inc, ptr.
  - Instantiated twice, for wr_ptr and rd_ptr.
- Storage is an inferred register/RAM array in the top module.

Test Plan:
- DEPTH=8, OVERWRITE=0: reset, write 1..8 -> full=1, count=8; write 9 -> dropped, overflow=1; read 8 times -> outputs 1..8 each with rd_valid one cycle after read_en, empty=1 afterwards.
- DEPTH=8, OVERWRITE=1: write 1..10, then read 8 -> outputs 3..10, overflow=1, count 8->0.
- DEPTH=5 (non-power-of-two): 3 rounds of write 4 / read 4 with data 1..12 -> outputs 1..12 in order; pointers wrap 4->0 without corruption.
- Empty buffer, read_en+write_en with data 0x00AA -> underflow=1, rd_valid=0, count=1; next cycle read -> 0x00AA.
- Full buffer (DEPTH=8, data 1..8), simultaneous read+write of 9 for 8 cycles -> outputs 1..8, count stays 8, overflow stays 0; then reading all 8 yields 9.
- Mid-stream: with count=5, pulse flush then assert npu_rst_n low for 1 cycle at a random point -> count=0, empty=1, flags=0 immediately on reset assertion; a subsequent write/read of 0x1234 returns 0x1234.

Source files
------------

// File: rtl/npu_buf_pkg.sv
// Shared constants and helpers for the NPU buffer family.
package npu_buf_pkg;

    // Overflow policy selectors
    localparam int OVF_DROP      = 0;
    localparam int OVF_OVERWRITE = 1;

    // Default geometry shared by NPU buffers
    localparam int NPU_BUF_DATA_W = 16;
    localparam int NPU_BUF_DEPTH  = 64;

    // Ceiling log2, usable in parameter expressions.
    // The loop is bounded so that it elaborates as a constant function.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/npu_circ_ptr.sv
// Modulo-DEPTH pointer register with synchronous clear and increment.
module npu_circ_ptr
    import npu_buf_pkg::*;
#(
    parameter int   DEPTH = NPU_BUF_DEPTH,
    localparam int  PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             npu_rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Next pointer: clear wins, otherwise wrap DEPTH-1 -> 0 by explicit compare
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    // Pointer state register
    always_ff @(posedge CLK or negedge npu_rst_n) begin
        if (!npu_rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/npu_circ_buf_param.sv
// Parametrised single-clock ring buffer with occupancy status,
// selectable overflow policy, sticky error flags and synchronous flush.
module npu_circ_buf_param
    import npu_buf_pkg::*;
#(
    parameter int  DATA_W    = NPU_BUF_DATA_W,
    parameter int  DEPTH     = NPU_BUF_DEPTH,
    parameter int  OVERWRITE = OVF_DROP,
    localparam int CNT_W     = clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              npu_rst_n,
    input  logic              npu_circ_buf_flush,
    input  logic              npu_circ_buf_write_en,
    input  logic [DATA_W-1:0] npu_circ_buf_data_input,
    input  logic              npu_circ_buf_read_en,
    output logic [DATA_W-1:0] npu_circ_buf_data_output,
    output logic              npu_circ_buf_rd_valid,
    output logic              npu_circ_buf_full,
    output logic              npu_circ_buf_empty,
    output logic [CNT_W-1:0]  npu_circ_buf_count,
    output logic              npu_circ_buf_overflow,
    output logic              npu_circ_buf_underflow
);

    localparam int PTR_W  = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam bit OVW_EN = (OVERWRITE == OVF_OVERWRITE);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic [CNT_W-1:0]  count_q,    count_d;
    logic [DATA_W-1:0] dout_q,     dout_d;
    logic              rd_valid_q, rd_valid_d;
    logic              ovf_q,      ovf_d;
    logic              unf_q,      unf_d;

    logic full;
    logic empty;
    logic rd_acc;
    logic wr_acc;
    logic wr_evict;

    // Status is decoded from the registered count only, so it never glitches
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Accept/reject decisions and next-state for count, read data and flags
    always_comb begin
        rd_acc     = npu_circ_buf_read_en & ~empty & ~npu_circ_buf_flush;
        // Overwrite-oldest only applies when full and no read frees a slot
        wr_evict   = npu_circ_buf_write_en & full & ~rd_acc & OVW_EN & ~npu_circ_buf_flush;
        wr_acc     = npu_circ_buf_write_en & ~npu_circ_buf_flush & (~full | rd_acc | wr_evict);

        count_d    = count_q;
        dout_d     = dout_q;
        rd_valid_d = 1'b0;
        ovf_d      = ovf_q;
        unf_d      = unf_q;

        if (npu_circ_buf_flush) begin
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            // An evicting write replaces an entry, so occupancy stays at DEPTH
            if (wr_acc && !rd_acc && !wr_evict) begin
                count_d = count_q + CNT_W'(1);
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - CNT_W'(1);
            end
            if (rd_acc) begin
                dout_d     = mem_q[rd_ptr];
                rd_valid_d = 1'b1;
            end
            if (npu_circ_buf_write_en && full && !rd_acc) begin
                ovf_d = 1'b1;
            end
            if (npu_circ_buf_read_en && empty) begin
                unf_d = 1'b1;
            end
        end
    end

    // Control and output registers
    always_ff @(posedge CLK or negedge npu_rst_n) begin
        if (!npu_rst_n) begin
            count_q    <= '0;
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            dout_q     <= dout_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Storage array; contents are intentionally left unreset
    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem_q[wr_ptr] <= npu_circ_buf_data_input;
        end
    end

    npu_circ_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .CLK       (CLK),
        .npu_rst_n (npu_rst_n),
        .clr       (npu_circ_buf_flush),
        .inc       (wr_acc),
        .ptr       (wr_ptr)
    );

    // The read pointer also advances when an overwrite discards the oldest entry
    npu_circ_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .CLK       (CLK),
        .npu_rst_n (npu_rst_n),
        .clr       (npu_circ_buf_flush),
        .inc       (rd_acc | wr_evict),
        .ptr       (rd_ptr)
    );

    assign npu_circ_buf_data_output = dout_q;
    assign npu_circ_buf_rd_valid    = rd_valid_q;
    assign npu_circ_buf_full        = full;
    assign npu_circ_buf_empty       = empty;
    assign npu_circ_buf_count       = count_q;
    assign npu_circ_buf_overflow    = ovf_q;
    assign npu_circ_buf_underflow   = unf_q;

endmodule

// File: tb/tb_npu_circ_buf_param.sv
// Bench for npu_circ_buf_param: three instances (DEPTH 8 drop, DEPTH 8
// overwrite, DEPTH 5 drop) driven one at a time against a queue model.
module tb_npu_circ_buf_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        fl   [3];
    logic        we   [3];
    logic        re   [3];
    logic [15:0] din  [3];
    logic [15:0] dout [3];
    logic        rv   [3];
    logic        fu   [3];
    logic        em   [3];
    logic        ov   [3];
    logic        un   [3];
    logic [3:0]  cnt  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D  = (g == 2) ? 5 : 8;
        localparam int O  = (g == 1) ? 1 : 0;
        localparam int CW = $clog2(D + 1);
        logic [CW-1:0] c;
        npu_circ_buf_param #(.DATA_W(16), .DEPTH(D), .OVERWRITE(O)) u_dut (
            .CLK                      (clk),
            .npu_rst_n                (rst_n),
            .npu_circ_buf_flush       (fl[g]),
            .npu_circ_buf_write_en    (we[g]),
            .npu_circ_buf_data_input  (din[g]),
            .npu_circ_buf_read_en     (re[g]),
            .npu_circ_buf_data_output (dout[g]),
            .npu_circ_buf_rd_valid    (rv[g]),
            .npu_circ_buf_full        (fu[g]),
            .npu_circ_buf_empty       (em[g]),
            .npu_circ_buf_count       (c),
            .npu_circ_buf_overflow    (ov[g]),
            .npu_circ_buf_underflow   (un[g])
        );
        assign cnt[g] = 4'(c);
    end

    int n_cmp = 0;
    int n_err = 0;
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [15:0] data;
        int          stamp;
    } rd_exp_t;

    rd_exp_t sb[$];
    int      model_q[$];
    bit      m_ovf, m_unf;
    int      cfg_depth = 8;
    int      cfg_ovw   = 0;
    int      cur       = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (dut %0d, t=%0t): got %0h expected %0h", name, cur, $time, act, exp);
        end
    endtask

    // Reference model: a FIFO queue plus the overflow/underflow rules
    task automatic model_step(input bit f, input bit w, input bit r, input logic [15:0] d);
        bit emp, ful, rd;
        if (f) begin
            model_q.delete();
            m_ovf = 0;
            m_unf = 0;
            return;
        end
        emp = (model_q.size() == 0);
        ful = (model_q.size() == cfg_depth);
        rd  = r && !emp;
        if (r && emp) m_unf = 1;
        if (rd) begin
            sb.push_back('{data: 16'(model_q[0]), stamp: edge_cnt + 1});
            void'(model_q.pop_front());
        end
        if (w) begin
            if (!ful || rd) begin
                model_q.push_back(int'(d));
            end else if (cfg_ovw != 0) begin
                void'(model_q.pop_front());
                model_q.push_back(int'(d));
                m_ovf = 1;
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic check_status();
        chk("count",     32'(cnt[cur]), 32'(model_q.size()));
        chk("full",      32'(fu[cur]),  32'(model_q.size() == cfg_depth));
        chk("empty",     32'(em[cur]),  32'(model_q.size() == 0));
        chk("overflow",  32'(ov[cur]),  32'(m_ovf));
        chk("underflow", 32'(un[cur]),  32'(m_unf));
    endtask

    // One clock of stimulus; called at posedge+1
    task automatic step(input bit f, input bit w, input bit r, input logic [15:0] d);
        fl[cur] = f; we[cur] = w; re[cur] = r; din[cur] = d;
        model_step(f, w, r, d);
        @(posedge clk);
        #1;
        fl[cur] = 1'b0; we[cur] = 1'b0; re[cur] = 1'b0;
        check_status();
    endtask

    // Asynchronous reset asserted mid-cycle, released on a falling edge
    task automatic do_reset(input int which, input int depth, input int ovw, input int dly);
        #(dly);
        rst_n = 1'b0;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
        model_q.delete();
        m_ovf = 0;
        m_unf = 0;
        cur       = which;
        cfg_depth = depth;
        cfg_ovw   = ovw;
        #1;
        chk("rst_count",     32'(cnt[cur]), 32'd0);
        chk("rst_empty",     32'(em[cur]),  32'd1);
        chk("rst_full",      32'(fu[cur]),  32'd0);
        chk("rst_overflow",  32'(ov[cur]),  32'd0);
        chk("rst_underflow", 32'(un[cur]),  32'd0);
        chk("rst_rd_valid",  32'(rv[cur]),  32'd0);
        chk("rst_dout",      32'(dout[cur]), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 16'($urandom));
        end
        step(0, 0, 0, 16'h0);
    endtask

    // Monitor: pop the scoreboard whenever a read result appears or is due
    initial begin
        rd_exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rv[cur] === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("rd_valid_spurious", 32'(rv[cur]), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rd_latency", 32'(edge_cnt), 32'(e.stamp));
                    chk("rd_data",    32'(dout[cur]), 32'(e.data));
                end
            end else if (sb.size() > 0 && sb[0].stamp <= edge_cnt) begin
                e = sb.pop_front();
                chk("rd_valid", 32'(rv[cur]), 32'd1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held;
        rst_n = 1'b0;
        for (int g = 0; g < 3; g++) begin
            fl[g] = 0; we[g] = 0; re[g] = 0; din[g] = '0;
        end
        #3;

        // DEPTH=8 drop: fill, overflow on ninth write, drain in order
        do_reset(0, 8, 0, 1);
        for (int i = 1; i <= 8; i++) step(0, 1, 0, 16'(i));
        step(0, 1, 0, 16'd9);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 16'h0);
        step(0, 0, 0, 16'h0);
        rand_run(300);

        // DEPTH=8 overwrite: ten writes keep the newest eight
        do_reset(1, 8, 1, 2);
        for (int i = 1; i <= 10; i++) step(0, 1, 0, 16'(i));
        for (int i = 0; i < 8; i++) step(0, 0, 1, 16'h0);
        step(0, 0, 0, 16'h0);
        rand_run(300);

        // DEPTH=5: pointers wrap at a non-power-of-two boundary
        do_reset(2, 5, 0, 1);
        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int i = 1; i <= 4; i++) step(0, 1, 0, 16'(rnd * 4 + i));
            for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h0);
        end
        step(0, 0, 0, 16'h0);
        rand_run(300);

        // Empty buffer: simultaneous read+write takes the write only
        do_reset(0, 8, 0, 3);
        step(0, 1, 1, 16'h00AA);
        step(0, 0, 1, 16'h0);
        step(0, 0, 0, 16'h0);

        // Full buffer: simultaneous read+write keeps count at DEPTH
        do_reset(0, 8, 0, 2);
        for (int i = 1; i <= 8; i++) step(0, 1, 0, 16'(i));
        for (int i = 0; i < 8; i++) step(0, 1, 1, 16'd9);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 16'h0);
        step(0, 0, 0, 16'h0);

        // Flush clears flags but holds data_output, then async reset mid-stream
        do_reset(0, 8, 0, 1);
        step(0, 1, 0, 16'h0055);
        step(0, 0, 1, 16'h0);
        step(0, 0, 1, 16'h0);
        for (int i = 1; i <= 5; i++) step(0, 1, 0, 16'(16'h100 + i));
        held = dout[cur];
        step(1, 1, 1, 16'hDEAD);
        chk("flush_hold_dout", 32'(dout[cur]), 32'(held));
        for (int i = 1; i <= 5; i++) step(0, 1, 0, 16'(16'h200 + i));
        do_reset(0, 8, 0, $urandom_range(1, 3));
        step(0, 1, 0, 16'h1234);
        step(0, 0, 1, 16'h0);
        step(0, 0, 0, 16'h0);
        chk("final_sb_drained", 32'(sb.size()), 32'd0);

        #20;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
